// File: rtl/gb_lcd_capture.sv
// Game Boy LCD pixel-stream capture into a double-buffered linear frame store.
// Tracks x/y/address, fills the frame with a blank colour while the LCD is off.
module gb_lcd_capture #(
  parameter int          H_PIXELS    = 160,
  parameter int          V_LINES     = 144,
  parameter logic [14:0] BLANK_COLOR = 15'h7FFF,
  parameter int          ADDR_W      = 15
) (
  input  logic              hclk,
  input  logic              reset,
  input  logic              lcd_clkena,
  input  logic [14:0]       lcd_data,
  input  logic [1:0]        lcd_mode,
  input  logic              lcd_on,
  input  logic              lcd_vsync,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [14:0]       fb_wr_data,
  output logic              fb_buf_sel,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_LINES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS*V_LINES-1);

  typedef enum logic [1:0] {WAIT_VSYNC, CAPTURE, BLANK_FILL, OFF_IDLE} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d, x_b;
  logic [YW-1:0]       y_q, y_d, y_b;
  logic [ADDR_W-1:0]   addr_q, addr_d, a_b;
  logic                vsync_q, ovr_q, ovr_d;
  logic                wr_en_q, wr_en_d, buf_sel_q, buf_sel_d;
  logic                done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [14:0]         wr_data_q, wr_data_d;
  logic                pix, vs_rise, do_cap;

  assign pix     = lcd_clkena & lcd_on & (lcd_mode == 2'b11);
  assign vs_rise = lcd_vsync & ~vsync_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    ovr_d     = ovr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    buf_sel_d = buf_sel_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    x_b       = x_q;
    y_b       = y_q;
    a_b       = addr_q;
    do_cap    = 1'b0;
    case (state_q)
      WAIT_VSYNC: begin
        if (!lcd_on) begin
          state_d = BLANK_FILL;
          addr_d  = '0;
          ovr_d   = 1'b0;
        end else if (vs_rise) begin
          state_d = CAPTURE;
          ovr_d   = 1'b0;
          x_b = '0; y_b = '0; a_b = '0;
          x_d = '0; y_d = '0; addr_d = '0;
          do_cap  = pix;
        end else if (pix && ovr_q) begin
          // Overrun after a completed frame: flag once, drop the pixel
          err_d = 1'b1;
          ovr_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (!lcd_on) begin
          state_d = BLANK_FILL;
          addr_d  = '0;
        end else begin
          if (vs_rise) begin
            // Short frame: restart, a same-cycle pixel becomes pixel 0
            err_d = 1'b1;
            x_b = '0; y_b = '0; a_b = '0;
            x_d = '0; y_d = '0; addr_d = '0;
          end
          do_cap = pix;
        end
      end
      BLANK_FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = BLANK_COLOR;
        addr_d    = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          done_d    = 1'b1;
          buf_sel_d = ~buf_sel_q;
          addr_d    = '0;
          state_d   = lcd_on ? WAIT_VSYNC : OFF_IDLE;
        end
      end
      OFF_IDLE: begin
        if (lcd_on) state_d = WAIT_VSYNC;
      end
      default: state_d = WAIT_VSYNC;
    endcase

    if (do_cap) begin
      wr_en_d   = 1'b1;
      wr_addr_d = a_b;
      wr_data_d = lcd_data;
      addr_d    = a_b + 1'b1;
      if (x_b == XW'(H_PIXELS-1)) begin
        x_d = '0;
        y_d = y_b + 1'b1;
      end else begin
        x_d = x_b + 1'b1;
      end
      if (x_b == XW'(H_PIXELS-1) && y_b == YW'(V_LINES-1)) begin
        done_d    = 1'b1;
        buf_sel_d = ~buf_sel_q;
        ovr_d     = 1'b1;
        state_d   = WAIT_VSYNC;
        x_d = '0; y_d = '0; addr_d = '0;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q   <= WAIT_VSYNC;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      vsync_q   <= 1'b0;
      ovr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      buf_sel_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      vsync_q   <= lcd_vsync;
      ovr_q     <= ovr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      buf_sel_q <= buf_sel_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign fb_wr_en   = wr_en_q;
  assign fb_wr_addr = wr_addr_q;
  assign fb_wr_data = wr_data_q;
  assign fb_buf_sel = buf_sel_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: full/short frames, LCD-off fill, qualification, overrun, reset.
module tb_gb_lcd_capture;
  localparam int TOTAL = 160*144;

  logic        hclk = 1'b0;
  logic        reset, lcd_clkena, lcd_on, lcd_vsync;
  logic [14:0] lcd_data;
  logic [1:0]  lcd_mode;
  logic        fb_wr_en, fb_buf_sel, frame_done, frame_err;
  logic [14:0] fb_wr_addr, fb_wr_data;

  int checks = 0, failures = 0;
  int wr_cnt = 0, err_cnt = 0, done_cnt = 0, bad = 0;

  gb_lcd_capture dut (
    .hclk(hclk), .reset(reset), .lcd_clkena(lcd_clkena), .lcd_data(lcd_data),
    .lcd_mode(lcd_mode), .lcd_on(lcd_on), .lcd_vsync(lcd_vsync),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .fb_buf_sel(fb_buf_sel), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample registered outputs just after the edge
  task automatic step();
    @(posedge hclk);
    #1;
    if (fb_wr_en)   wr_cnt++;
    if (frame_err)  err_cnt++;
    if (frame_done) done_cnt++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},   32'(fb_wr_en),   0);
    chk({tag, "_addr"}, 32'(fb_wr_addr), 0);
    chk({tag, "_data"}, 32'(fb_wr_data), 0);
    chk({tag, "_sel"},  32'(fb_buf_sel), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_err"},  32'(frame_err),  0);
  endtask

  initial begin
    reset = 1'b1; lcd_clkena = 1'b0; lcd_on = 1'b1; lcd_vsync = 1'b0;
    lcd_data = '0; lcd_mode = 2'b11;
    step(); step();
    chk_reset("rst");
    reset = 1'b0;
    step();

    // Full frame: vsync rise with pixel 0 in the same cycle
    bad = 0; err_cnt = 0;
    lcd_vsync = 1'b1; lcd_clkena = 1'b1;
    for (int i = 0; i < TOTAL; i++) begin
      lcd_data = 15'(i);
      step();
      if (!(fb_wr_en && fb_wr_addr == 15'(i) && fb_wr_data == 15'(i))) bad++;
      if (i < TOTAL-1 && (frame_done || fb_buf_sel)) bad++;
    end
    chk("full_writes", bad, 0);
    chk("full_done", 32'(frame_done), 1);
    chk("full_sel", 32'(fb_buf_sel), 1);
    chk("full_no_err", err_cnt, 0);

    // Overrun: 3 pixels before the next vsync rise
    wr_cnt = 0; err_cnt = 0; lcd_data = 15'h5555;
    repeat (3) step();
    lcd_clkena = 1'b0;
    step();
    chk("overrun_err", err_cnt, 1);
    chk("overrun_wr", wr_cnt, 0);

    // Short frame: 1000 pixels then vsync rise with a same-cycle pixel
    lcd_vsync = 1'b0;
    step();
    lcd_vsync = 1'b1; lcd_clkena = 1'b1; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      lcd_data = 15'(i);
      step();
      if (!(fb_wr_en && fb_wr_addr == 15'(i) && fb_wr_data == 15'(i) && !frame_err)) bad++;
    end
    chk("short_writes", bad, 0);
    lcd_vsync = 1'b0; lcd_clkena = 1'b0;
    step();
    lcd_vsync = 1'b1; lcd_clkena = 1'b1; lcd_data = 15'h1234;
    step();
    chk("short_err", 32'(frame_err), 1);
    chk("short_en", 32'(fb_wr_en), 1);
    chk("short_addr", 32'(fb_wr_addr), 0);
    chk("short_data", 32'(fb_wr_data), 32'h1234);
    chk("short_sel", 32'(fb_buf_sel), 1);

    // LCD off after 500 pixels of the new frame
    bad = 0;
    for (int i = 1; i < 500; i++) begin
      lcd_data = 15'(i);
      step();
      if (!(fb_wr_en && fb_wr_addr == 15'(i))) bad++;
    end
    chk("pre_off_writes", bad, 0);
    lcd_on = 1'b0; lcd_clkena = 1'b0;
    err_cnt = 0; done_cnt = 0; bad = 0;
    step();
    chk("off_nowrite", 32'(fb_wr_en), 0);
    for (int i = 0; i < TOTAL; i++) begin
      step();
      if (!(fb_wr_en && fb_wr_addr == 15'(i) && fb_wr_data == 15'h7FFF)) bad++;
    end
    chk("fill_writes", bad, 0);
    chk("fill_done", 32'(frame_done), 1);
    chk("fill_sel", 32'(fb_buf_sel), 0);
    chk("fill_done_cnt", done_cnt, 1);
    chk("fill_no_err", err_cnt, 0);
    wr_cnt = 0;
    lcd_vsync = 1'b0; step();
    lcd_vsync = 1'b1; step();
    repeat (3) step();
    chk("off_idle_wr", wr_cnt, 0);

    // Qualification: only mode 3 with LCD on produces writes
    lcd_on = 1'b1; lcd_clkena = 1'b1; lcd_mode = 2'b11;
    wr_cnt = 0; err_cnt = 0;
    step(); step();
    lcd_vsync = 1'b0; lcd_clkena = 1'b0;
    step();
    lcd_vsync = 1'b1;
    step();
    for (int m = 0; m < 3; m++) begin
      lcd_mode = 2'(m); lcd_clkena = 1'b1;
      step();
    end
    chk("qual_wr", wr_cnt, 0);
    chk("qual_err", err_cnt, 0);
    lcd_mode = 2'b11; lcd_data = 15'h0ABC;
    step();
    chk("qual_en", 32'(fb_wr_en), 1);
    chk("qual_addr", 32'(fb_wr_addr), 0);
    chk("qual_data", 32'(fb_wr_data), 32'h0ABC);

    // LCD off in WAIT_VSYNC starts a fill; reset aborts it at write 100
    reset = 1'b1; lcd_clkena = 1'b0;
    step();
    reset = 1'b0; lcd_on = 1'b0; lcd_clkena = 1'b1;
    step();
    chk("wait_off_nowrite", 32'(fb_wr_en), 0);
    lcd_clkena = 1'b0; bad = 0; done_cnt = 0; err_cnt = 0;
    for (int i = 0; i <= 100; i++) begin
      step();
      if (!(fb_wr_en && fb_wr_addr == 15'(i) && fb_wr_data == 15'h7FFF)) bad++;
    end
    chk("fill2_writes", bad, 0);
    reset = 1'b1;
    step();
    chk_reset("midfill_rst");
    chk("midfill_no_done", done_cnt, 0);
    chk("midfill_no_err", err_cnt, 0);
    reset = 1'b0; lcd_on = 1'b1; lcd_clkena = 1'b1; lcd_mode = 2'b11;
    lcd_vsync = 1'b0; wr_cnt = 0;
    repeat (4) step();
    chk("post_rst_wait", wr_cnt, 0);
    lcd_vsync = 1'b1; lcd_data = 15'h0042;
    step();
    chk("post_rst_en", 32'(fb_wr_en), 1);
    chk("post_rst_addr", 32'(fb_wr_addr), 0);
    chk("post_rst_data", 32'(fb_wr_data), 32'h0042);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gb_lcd_capture.md
# gb_lcd_capture

Captures the Game Boy core's LCD pixel stream (`gb_lcd_clkena`, `gb_lcd_data`, `gb_lcd_mode`, `gb_lcd_on`, `gb_lcd_vsync`) and turns it into linear frame-buffer writes for a double-buffered 160x144 RGB555 frame store. It sits directly downstream of `emu_system_top`, in the `hclk` domain. It tracks x/y position and fills the frame with a blank colour when the LCD is switched off. It signals frame completion so the display side can flip buffers.

## Interface
- `H_PIXELS`, 160, pixels per line
- `V_LINES`, 144, lines per frame
- `BLANK_COLOR`, 15'h7FFF, fill value written while the LCD is off
- `ADDR_W`, 15, frame-buffer address width (must hold `H_PIXELS*V_LINES-1`)

Ports:
- `hclk` in 1: single clock, same as the emulator core
- `reset` in 1: synchronous, active-high
- `lcd_clkena` in 1: pixel strobe from the core
- `lcd_data` in 15: RGB555 pixel
- `lcd_mode` in 2: PPU mode; only 2'b11 qualifies pixels
- `lcd_on` in 1: LCD enable
- `lcd_vsync` in 1: frame sync, level; its rising edge starts a frame
- `fb_wr_en` out 1: frame-buffer write strobe
- `fb_wr_addr` out ADDR_W: linear address, `y*H_PIXELS + x`
- `fb_wr_data` out 15: write data
- `fb_buf_sel` out 1: buffer currently being written; the other buffer is displayable
- `frame_done` out 1: one-cycle pulse when a frame (or blank fill) completes
- `frame_err` out 1: one-cycle pulse on a short or over-long frame

## Operation
- Pixel accept: `pix = lcd_clkena & lcd_on & (lcd_mode==2'b11)`.
- Vsync edge: `vs_rise = lcd_vsync & ~vsync_q`, where `vsync_q` is registered each cycle.
- Counters: `x` runs 0..H_PIXELS-1 and `y` runs 0..V_LINES-1. `addr` is a running counter incremented per write; there is no multiplier.
- **WAIT_VSYNC** (reset state):
  - `lcd_on=0` goes to BLANK_FILL.
  - `vs_rise` clears x/y/addr and goes to CAPTURE. A `pix` in the same cycle is captured as pixel 0.
  - Any other `pix` is dropped.
- **CAPTURE**, on each `pix`:
  - Write `lcd_data` to `addr`, then increment.
  - When `x==H_PIXELS-1`: set `x=0` and increment `y`.
  - On the last pixel (x=159, y=143): pulse `frame_done`, toggle `fb_buf_sel`, go to WAIT_VSYNC.
- **CAPTURE exceptions**:
  - `vs_rise` before the last pixel: pulse `frame_err`, clear counters, stay in CAPTURE. `fb_buf_sel` is not toggled. A same-cycle `pix` becomes pixel 0 of the new frame.
  - `lcd_on` falling: abandon the frame with no `frame_err` and go to BLANK_FILL.
- **Overrun**: a `pix` in WAIT_VSYNC that arrives after a completed frame and before `vs_rise` pulses `frame_err` once per frame and is dropped.
- **BLANK_FILL**:
  - Write `BLANK_COLOR` to addresses 0..H_PIXELS*V_LINES-1, one per cycle, starting from 0.
  - After the final write: pulse `frame_done` and toggle `fb_buf_sel`.
  - Then go to WAIT_VSYNC if `lcd_on=1`, else OFF_IDLE.
  - The fill always runs to completion; `lcd_on` rising and `vs_rise` are ignored during the fill.
- **OFF_IDLE**: no writes. `lcd_on=1` goes to WAIT_VSYNC.

## Timing
- All outputs are registered.
- Write latency is 1 cycle: a `pix` or fill step in cycle N gives `fb_wr_en=1` with address and data in cycle N+1.
- `frame_done` and the `fb_buf_sel` toggle appear in the same cycle as the final write's `fb_wr_en`.
- The edge detector adds no latency: `vs_rise` acts in the cycle `lcd_vsync` first reads 1.
- Fill duration is exactly H_PIXELS*V_LINES cycles (23040 at defaults) of continuous `fb_wr_en`.
- Reset values:
  - `fb_wr_en=0`, `fb_wr_addr=0`, `fb_wr_data=0`, `fb_buf_sel=0`, `frame_done=0`, `frame_err=0`
  - state WAIT_VSYNC, counters 0, `vsync_q=0`
- `reset` mid-frame or mid-fill aborts immediately, with no `frame_done` or `frame_err`.
- `fb_wr_en` is high for at most one write per cycle; the downstream RAM accepts a write every cycle.

## Test plan
- **Full frame**: `lcd_on=1`, mode 3, `vs_rise`, then 23040 `pix` with data = pixel index[14:0].
  - Expect 23040 writes with addr = data = 0..23039.
  - Expect `frame_done` on the last write and `fb_buf_sel` 0->1.
- **Short frame**: `vs_rise`, 1000 pixels, `vs_rise` with a same-cycle pixel.
  - Expect `frame_err` pulse, the next write at addr 0, and `fb_buf_sel` unchanged.
- **LCD off mid-frame**: after 500 pixels, drop `lcd_on`.
  - Expect 23040 consecutive writes of 15'h7FFF at addr 0..23039.
  - Then `frame_done` and toggle, then OFF_IDLE with no further writes.
- **Qualification**: `lcd_clkena` pulses with mode 0/1/2, or with `lcd_on=0` in WAIT_VSYNC.
  - Expect no pixel writes; `lcd_on=0` instead starts a fill.
- **Overrun**: after a complete frame, 3 extra `pix` before vsync.
  - Expect exactly one `frame_err` and no writes.
- **Reset**: assert `reset` during fill at write 100.
  - Next cycle all outputs are at reset values; with `lcd_on=1`, the block waits for `vs_rise`.
